// File: rtl/adder_rr_arbiter_if.sv
// Requester/consumer bundle for the shared round-robin adder.
// master drives requests and consumes sums; slave is the arbiter side.
interface adder_rr_arbiter_if #(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDW   = 2
);
    logic [N-1:0]       req;
    logic [N*WIDTH-1:0] op_a;
    logic [N*WIDTH-1:0] op_b;
    logic [N-1:0]       gnt;
    logic [WIDTH:0]     sum_out;
    logic [IDW-1:0]     sum_id;
    logic               sum_valid;
    logic               sum_ready;

    modport master (
        output req, op_a, op_b, sum_ready,
        input  gnt, sum_out, sum_id, sum_valid
    );

    modport slave (
        input  req, op_a, op_b, sum_ready,
        output gnt, sum_out, sum_id, sum_valid
    );
endinterface

// File: rtl/adder_rr_arbiter.sv
// One registered adder shared by N requesters under round-robin arbitration,
// returning a tagged WIDTH+1-bit sum through a valid/ready output stage.
module adder_rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDW   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    adder_rr_arbiter_if.slave   bus
);
    localparam int unsigned SW = WIDTH + 1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [SW-1:0]  sum_q, sum_d;
    logic [IDW-1:0] id_q, id_d;
    logic [IDW-1:0] ptr_q, ptr_d;

    logic           can_issue;
    logic           hit;
    logic [IDW-1:0] sel;
    logic [IDW-1:0] idx;
    logic [WIDTH-1:0] a_sel, b_sel;

    assign can_issue = (state_q == IDLE) || bus.sum_ready;

    // Scan from the farthest offset down so the requester nearest ptr wins.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        idx = '0;
        for (int j = int'(N) - 1; j >= 0; j--) begin
            idx = IDW'((int'(ptr_q) + j) % int'(N));
            if (bus.req[idx]) begin
                hit = 1'b1;
                sel = idx;
            end
        end
        if (!rst_n || !can_issue) begin
            hit = 1'b0;
        end
    end

    assign a_sel   = bus.op_a[sel*WIDTH +: WIDTH];
    assign b_sel   = bus.op_b[sel*WIDTH +: WIDTH];
    assign bus.gnt = hit ? (N'(1) << sel) : '0;

    // Next-state: issue loads the adder result, a free slot with no issue drains.
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        if (hit) begin
            state_d = HOLD;
            sum_d   = SW'(a_sel) + SW'(b_sel);
            id_d    = sel;
            ptr_d   = (sel == IDW'(N - 1)) ? '0 : sel + IDW'(1);
        end else if (can_issue) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sum_q   <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.sum_valid = (state_q == HOLD);
    assign bus.sum_out   = sum_q;
    assign bus.sum_id    = id_q;
endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed and randomized checks of adder_rr_arbiter against a cycle-level
// reference model built from the arbitration rules.
module tb_adder_rr_arbiter;
    localparam int unsigned N     = 4;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned IDW   = 2;

    logic clk;
    logic rst_n;

    adder_rr_arbiter_if #(.N(N), .WIDTH(WIDTH), .IDW(IDW)) bus ();

    adder_rr_arbiter #(.N(N), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int   m_ptr;
    bit   m_valid;
    int   m_sum;
    int   m_id;
    bit   m_known = 1'b0;
    int   opa [N];
    int   opb [N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] rq);
        for (int j = 0; j < int'(N); j++) begin
            if (rq[(m_ptr + j) % int'(N)]) return (m_ptr + j) % int'(N);
        end
        return -1;
    endfunction

    task automatic drive_ops();
        for (int i = 0; i < int'(N); i++) begin
            bus.op_a[i*WIDTH +: WIDTH] = WIDTH'(opa[i]);
            bus.op_b[i*WIDTH +: WIDTH] = WIDTH'(opb[i]);
        end
    endtask

    // One clock: drive, check at negedge, advance model, return just after posedge.
    task automatic step(input logic r, input logic [N-1:0] rq, input logic rdy,
                        output logic [N-1:0] g);
        int k;
        logic [N-1:0] eg;
        rst_n         = r;
        bus.req       = rq;
        bus.sum_ready = rdy;
        drive_ops();
        @(negedge clk);
        eg = '0;
        k  = -1;
        if (r && (!m_valid || rdy || !m_known)) k = pick(rq);
        if (k >= 0) eg[k] = 1'b1;
        g = bus.gnt;
        check("gnt", 32'(bus.gnt), 32'(eg));
        if (m_known) begin
            check("sum_valid", 32'(bus.sum_valid), 32'(m_valid));
            check("sum_out",   32'(bus.sum_out),   32'(m_sum));
            check("sum_id",    32'(bus.sum_id),    32'(m_id));
        end
        if (!r) begin
            m_known = 1'b1;
            m_valid = 1'b0;
            m_sum   = 0;
            m_id    = 0;
            m_ptr   = 0;
        end else if (k >= 0) begin
            m_valid = 1'b1;
            m_sum   = opa[k] + opb[k];
            m_id    = k;
            m_ptr   = (k + 1) % int'(N);
        end else if (!m_valid || rdy) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    logic [N-1:0] g;

    initial begin
        m_ptr = 0; m_valid = 1'b0; m_sum = 0; m_id = 0;
        for (int i = 0; i < int'(N); i++) begin opa[i] = 0; opb[i] = 0; end
        rst_n = 1'b0; bus.req = '0; bus.sum_ready = 1'b0;
        drive_ops();
        @(posedge clk); #1;

        // Reset with all requesting
        step(1'b0, 4'b1111, 1'b1, g);
        check("rst_gnt0", 32'(g), 32'h0);
        check("rst_valid", 32'(bus.sum_valid), 32'h0);
        check("rst_sum", 32'(bus.sum_out), 32'h0);
        step(1'b0, 4'b1111, 1'b1, g);
        check("rst_gnt1", 32'(g), 32'h0);

        // Single requester, maximal carry
        opa[2] = 255; opb[2] = 255;
        step(1'b1, 4'b0100, 1'b1, g);
        check("single_gnt", 32'(g), 32'h4);
        check("single_sum", 32'(bus.sum_out), 32'd510);
        check("single_id", 32'(bus.sum_id), 32'd2);
        step(1'b1, 4'b0000, 1'b1, g);
        check("single_drain", 32'(bus.sum_valid), 32'h0);

        // Round-robin with all requesting (ptr=3 after serving 2)
        for (int i = 0; i < int'(N); i++) begin opa[i] = i; opb[i] = 10 * i; end
        for (int c = 0; c < 5; c++) begin
            step(1'b1, 4'b1111, 1'b1, g);
            check("rr_id", 32'(bus.sum_id), 32'((c + 3) % 4));
            check("rr_sum", 32'(bus.sum_out), 32'(11 * ((c + 3) % 4)));
        end

        // Backpressure: hold id 1 / sum 20 for three stalled cycles
        opa[1] = 5; opb[1] = 15;
        step(1'b1, 4'b0010, 1'b1, g);
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 4'b1001, 1'b0, g);
            check("bp_gnt", 32'(g), 32'h0);
            check("bp_sum", 32'(bus.sum_out), 32'd20);
            check("bp_id", 32'(bus.sum_id), 32'd1);
        end
        step(1'b1, 4'b1001, 1'b1, g);
        check("bp_release_gnt", 32'(g), 32'h8);
        check("bp_release_id", 32'(bus.sum_id), 32'd3);

        // Wrap to 0, then requester 1 drops before its grant
        step(1'b1, 4'b0011, 1'b1, g);
        check("wrap_gnt", 32'(g), 32'h1);
        step(1'b1, 4'b0011, 1'b0, g);
        check("skip_stall", 32'(g), 32'h0);
        step(1'b1, 4'b0001, 1'b1, g);
        check("skip_gnt", 32'(g), 32'h1);
        check("skip_id", 32'(bus.sum_id), 32'd0);

        // Mid-operation reset with a pending sum and ptr=2
        step(1'b1, 4'b0010, 1'b1, g);
        step(1'b0, 4'b1111, 1'b0, g);
        check("mrst_valid", 32'(bus.sum_valid), 32'h0);
        step(1'b1, 4'b1111, 1'b1, g);
        check("mrst_first_gnt", 32'(g), 32'h1);

        // Randomized traffic, backpressure and occasional reset
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < int'(N); i++) begin
                opa[i] = int'($urandom_range(0, 255));
                opb[i] = int'($urandom_range(0, 255));
            end
            step(($urandom_range(0, 39) != 0), N'($urandom), ($urandom_range(0, 3) != 0), g);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
